// File: rtl/capture_trigger_ctrl.sv
// Turns each debounced button press into one vsync-aligned capture handshake.
// Optional macro CAP_TRIG_QUEUE_EN: hold one press that arrives while busy.
module capture_trigger_ctrl #(
    parameter logic        ACTIVE_LVL = 1'b0,
    parameter logic        VS_POL     = 1'b1,
    parameter logic [23:0] TIMEOUT    = 24'd10000000,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             vsync,
    input  logic             cap_ack,
    input  logic             cap_done,
    output logic             cap_req,
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] cap_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_REQ,
        S_CAPTURE
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_btn_q;
    logic             r_vs_s1;
    logic             r_vs_s2;
    logic             r_vs_s3;
    logic [23:0]      r_timer;
    logic             r_cap_req;
    logic             r_busy;
    logic             r_err;
    logic [CNT_W-1:0] r_count;
    logic             w_trig;
    logic             w_vs_start;
    logic             w_timeout;
    logic             w_pend;
    logic             w_start;
    logic             w_done;
    logic             w_to;

    assign w_trig     = (btn_in == ACTIVE_LVL) && (r_btn_q != ACTIVE_LVL);
    assign w_vs_start = (r_vs_s2 == VS_POL) && (r_vs_s3 != VS_POL);
    assign w_timeout  = (r_state != S_IDLE) && (r_timer == TIMEOUT - 24'd1);

`ifdef CAP_TRIG_QUEUE_EN
    logic r_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
        end else if (w_start) begin
            r_pending <= 1'b0;
        end else if (r_state != S_IDLE && w_trig) begin
            r_pending <= 1'b1;
        end
    end

    assign w_pend = r_pending;
`else
    assign w_pend = 1'b0;
`endif

    // Completion always takes priority over a coincident timeout.
    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_done     = 1'b0;
        w_to       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_trig || w_pend) begin
                    w_state_nx = S_WAIT_VS;
                    w_start    = 1'b1;
                end
            end
            S_WAIT_VS: begin
                if (w_timeout) begin
                    w_state_nx = S_IDLE;
                    w_to       = 1'b1;
                end else if (w_vs_start) begin
                    w_state_nx = S_REQ;
                end
            end
            S_REQ: begin
                if (cap_ack && cap_done) begin
                    w_state_nx = S_IDLE;
                    w_done     = 1'b1;
                end else if (w_timeout) begin
                    w_state_nx = S_IDLE;
                    w_to       = 1'b1;
                end else if (cap_ack) begin
                    w_state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (cap_done) begin
                    w_state_nx = S_IDLE;
                    w_done     = 1'b1;
                end else if (w_timeout) begin
                    w_state_nx = S_IDLE;
                    w_to       = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_btn_q   <= ~ACTIVE_LVL;
            r_vs_s1   <= ~VS_POL;
            r_vs_s2   <= ~VS_POL;
            r_vs_s3   <= ~VS_POL;
            r_timer   <= 24'd0;
            r_cap_req <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_btn_q   <= btn_in;
            r_vs_s1   <= vsync;
            r_vs_s2   <= r_vs_s1;
            r_vs_s3   <= r_vs_s2;
            r_cap_req <= (w_state_nx == S_REQ);
            r_busy    <= (w_state_nx != S_IDLE);
            if (r_state == S_IDLE) begin
                r_timer <= 24'd0;
            end else if (r_timer != 24'hFFFFFF) begin
                r_timer <= r_timer + 24'd1;
            end
            if (w_start) begin
                r_err <= 1'b0;
            end else if (w_to) begin
                r_err <= 1'b1;
            end
            if (w_done) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign cap_req     = r_cap_req;
    assign busy        = r_busy;
    assign err_timeout = r_err;
    assign cap_count   = r_count;

endmodule

// File: doc/capture_trigger_ctrl.md
Name: capture_trigger_ctrl

Overview:
Consumes the debounced, stretched button pulse produced by the slow input flop stage and turns each press into exactly one frame-aligned capture request to the frame capture/write path. Detects the press edge, waits for the next frame start (vsync), runs a req/ack/done handshake with the capture engine, and reports busy, timeout error and a capture count. Sits between the front-panel input conditioning and the HDMI frame capture logic.

Parameters:
ACTIVE_LVL, 1'b0, level of btn_in meaning "pressed"; matches an upstream idle default of 1.
VS_POL, 1'b1, active polarity of vsync; the frame start is the edge into this level.
TIMEOUT, 24'd10000000, max cycles from leaving IDLE to cap_done before aborting; legal range 4..2^24-1.
CNT_W, 8, width of cap_count.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
btn_in  input  1  conditioned button pulse from the upstream flop; synchronous to clk; may stay active several cycles
vsync  input  1  frame sync from the HDMI receiver; treated as asynchronous to clk
cap_ack  input  1  capture engine has accepted the request
cap_done  input  1  capture engine finished writing the frame; 1-cycle pulse
cap_req  output  1  capture request, registered
busy  output  1  1 whenever state != IDLE, registered
err_timeout  output  1  sticky timeout flag, registered
cap_count  output  CNT_W  number of completed captures, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, async): state=IDLE, cap_req=0, busy=0, err_timeout=0, cap_count=0, btn_q=~ACTIVE_LVL, vsync sync flops=~VS_POL, timer=0, pending=0. Reset mid-handshake abandons the transaction; no completion is counted.
- Press edge: btn_q registers btn_in. trig = (btn_in==ACTIVE_LVL) && (btn_q!=ACTIVE_LVL). A pulse held N cycles yields exactly one trig.
- Frame start: vsync passes a 2-flop synchronizer, then a third register for edge detection. vs_start = 1 for one cycle on the synchronized transition to VS_POL. Latency is 3 clk cycles from a vsync edge.
- FSM transitions:
  - IDLE: on trig, go to WAIT_VS next cycle, clear err_timeout and timer.
  - WAIT_VS: on vs_start, go to REQ. A vs_start in the same cycle as the trig that leaves IDLE is not used; the bench waits for the next frame.
  - REQ: cap_req=1 throughout. When cap_ack=1 is sampled, go to CAPTURE and drop cap_req the next cycle. If cap_ack and cap_done are both 1 in the same cycle, go to IDLE and increment cap_count.
  - CAPTURE: on cap_done, go to IDLE and increment cap_count.
- cap_req rises the cycle the state becomes REQ and falls the cycle the state leaves REQ.
- Timer:
  - Counts every cycle the state != IDLE and saturates.
  - When timer reaches TIMEOUT-1 with no completion in that cycle, go to IDLE, set err_timeout=1 and drop cap_req. cap_count does not increment.
  - If cap_done and timeout occur in the same cycle, cap_done wins.
- trig while busy: dropped (see the optional feature). cap_ack or cap_done outside the expected state is ignored.
- cap_count wraps from 2^CNT_W-1 to 0.

Optional Feature:
CAP_TRIG_QUEUE_EN
- Defined: a trig while busy sets a one-deep pending flag; further trigs while pending is set are dropped. On the cycle the FSM enters IDLE with pending=1, it goes straight to WAIT_VS on the next cycle, clears pending and clears err_timeout. This holds after timeout too.
- Undefined: no pending flag; every trig while busy is discarded.

Test Plan:
- Reset, then btn_in held 0 for 3 cycles (ACTIVE_LVL=0) -> busy=1 one cycle after the first low sample; one transaction only; cap_req stays 0 until 3 cycles after the next vsync rising edge.
- vsync rises, cap_ack given 2 cycles after cap_req, cap_done 10 cycles later -> cap_req high exactly 3 cycles (ack+1); cap_count 0->1; busy=0 the cycle after cap_done.
- TIMEOUT=100, no cap_ack -> at timer=99 state returns to IDLE, err_timeout=1, cap_req=0, cap_count unchanged; next press clears err_timeout.
- Second press during CAPTURE -> without the macro, cap_count ends at 1 and exactly one cap_req. With CAP_TRIG_QUEUE_EN, a second WAIT_VS starts one cycle after IDLE and cap_count ends at 2.
- cap_ack and cap_done high in the same cycle in REQ -> IDLE next cycle, cap_count +1, no CAPTURE state. cap_done and timeout in the same cycle -> counted, err_timeout=0.
- CNT_W=2, 5 complete captures -> cap_count sequence 1,2,3,0,1; rst pulsed low mid-REQ -> all outputs 0 immediately and asynchronously.
